// File: rtl/instr_flow_ctrl_if.sv
// Decoder/controller bundle for the instruction flow controller.
// Master drives requests and ptr_in; slave drives the pointer strobes.
interface instr_flow_ctrl_if #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 8
);
    localparam int DW = $clog2(STACK_DEPTH) + 1;

    logic             start;
    logic             stall;
    logic             halt_req;
    logic             jump_req;
    logic [WIDTH-1:0] jump_addr;
    logic             call_req;
    logic [WIDTH-1:0] call_addr;
    logic             ret_req;
    logic             fault_clr;
    logic [WIDTH-1:0] ptr_in;

    logic             ptr_enable;
    logic             ptr_load_enable;
    logic [WIDTH-1:0] ptr_load_val;
    logic             ptr_reset;
    logic             running;
    logic             halted;
    logic             fault;
    logic [1:0]       fault_code;
    logic [DW-1:0]    stack_depth;

    modport master (
        output start, stall, halt_req, jump_req, jump_addr,
        output call_req, call_addr, ret_req, fault_clr, ptr_in,
        input  ptr_enable, ptr_load_enable, ptr_load_val, ptr_reset,
        input  running, halted, fault, fault_code, stack_depth
    );

    modport slave (
        input  start, stall, halt_req, jump_req, jump_addr,
        input  call_req, call_addr, ret_req, fault_clr, ptr_in,
        output ptr_enable, ptr_load_enable, ptr_load_val, ptr_reset,
        output running, halted, fault, fault_code, stack_depth
    );
endinterface

// File: rtl/instr_flow_ctrl.sv
// Instruction pointer sequencer with a hardware return-address stack.
// Strobes are Mealy so the pointer loads in the cycle a request is taken.
module instr_flow_ctrl #(
    parameter int               WIDTH       = 8,
    parameter int               STACK_DEPTH = 8,
    parameter logic [WIDTH-1:0] START_ADDR  = '0
) (
    input  logic             clk,
    input  logic             reset,
    instr_flow_ctrl_if.slave bus
);
    localparam int              AW   = $clog2(STACK_DEPTH);
    localparam int              DW   = AW + 1;
    localparam logic [DW-1:0]   FULL = DW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    sp_q, sp_d;
    logic [1:0]       fcode_q, fcode_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    logic             en;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             push;
    logic [WIDTH-1:0] push_val;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;

    assign top_idx  = AW'(sp_q - 1'b1);
    assign wr_idx   = sp_q[AW-1:0];
    assign push_val = bus.ptr_in + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sp_q    <= '0;
            fcode_q <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            fcode_q <= fcode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[wr_idx] <= push_val;
        end
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        fcode_d = fcode_q;
        en      = 1'b0;
        ld      = 1'b0;
        ld_val  = '0;
        push    = 1'b0;
        unique case (state_q)
            IDLE, HALTED: begin
                if (bus.start) begin
                    ld      = 1'b1;
                    ld_val  = START_ADDR;
                    sp_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Fixed priority; lower-priority requests are dropped.
                if (!bus.stall) begin
                    if (bus.halt_req) begin
                        state_d = HALTED;
                    end else if (bus.ret_req) begin
                        if (sp_q == '0) begin
                            fcode_d = 2'd2;
                            state_d = FAULT;
                        end else begin
                            ld     = 1'b1;
                            ld_val = stack_q[top_idx];
                            sp_d   = sp_q - 1'b1;
                        end
                    end else if (bus.call_req) begin
                        if (sp_q == FULL) begin
                            fcode_d = 2'd1;
                            state_d = FAULT;
                        end else begin
                            push   = 1'b1;
                            sp_d   = sp_q + 1'b1;
                            ld     = 1'b1;
                            ld_val = bus.call_addr;
                        end
                    end else if (bus.jump_req) begin
                        ld     = 1'b1;
                        ld_val = bus.jump_addr;
                    end else begin
                        en = 1'b1;
                    end
                end
            end
            FAULT: begin
                if (bus.fault_clr) begin
                    state_d = IDLE;
                    fcode_d = '0;
                    sp_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset aborts whatever was accepted this cycle.
        if (reset) begin
            en     = 1'b0;
            ld     = 1'b0;
            ld_val = '0;
            push   = 1'b0;
        end
    end

    assign bus.ptr_enable      = en;
    assign bus.ptr_load_enable = ld;
    assign bus.ptr_load_val    = ld_val;
    assign bus.ptr_reset       = reset;
    assign bus.running         = (state_q == RUN);
    assign bus.halted          = (state_q == HALTED);
    assign bus.fault           = (state_q == FAULT);
    assign bus.fault_code      = fcode_q;
    assign bus.stack_depth     = sp_q;
endmodule

// File: tb/tb_instr_flow_ctrl.sv
// Directed bench for instr_flow_ctrl with a queue of expected results.
// Strobes checked mid-cycle, registered outputs checked after the edge.
module tb_instr_flow_ctrl;
    localparam int W = 8;
    localparam int D = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_FLT  = 2'd3;

    typedef struct {
        string      tag;
        logic       en;
        logic       ld;
        logic [7:0] val;
        logic [1:0] st;
        logic [1:0] fc;
        logic [3:0] dep;
    } exp_t;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    exp_t sb[$];

    instr_flow_ctrl_if #(.WIDTH(W), .STACK_DEPTH(D)) bus ();

    instr_flow_ctrl #(
        .WIDTH(W),
        .STACK_DEPTH(D),
        .START_ADDR(8'h00)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        bus.halt_req  = 1'b0;
        bus.jump_req  = 1'b0;
        bus.jump_addr = '0;
        bus.call_req  = 1'b0;
        bus.call_addr = '0;
        bus.ret_req   = 1'b0;
        bus.fault_clr = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step(string tag, logic en, logic ld, logic [7:0] val,
                        logic [1:0] st, logic [1:0] fc, logic [3:0] dep);
        exp_t e;
        exp_t g;
        e = '{tag: tag, en: en, ld: ld, val: val, st: st, fc: fc, dep: dep};
        sb.push_back(e);
        #2;
        g = sb.pop_front();
        chk({g.tag, ".en"}, 32'(bus.ptr_enable), 32'(g.en));
        chk({g.tag, ".ld"}, 32'(bus.ptr_load_enable), 32'(g.ld));
        chk({g.tag, ".val"}, 32'(bus.ptr_load_val), 32'(g.val));
        chk({g.tag, ".prst"}, 32'(bus.ptr_reset), 32'(reset));
        @(posedge clk);
        #1;
        chk({g.tag, ".run"}, 32'(bus.running), 32'(g.st == S_RUN));
        chk({g.tag, ".hlt"}, 32'(bus.halted), 32'(g.st == S_HALT));
        chk({g.tag, ".flt"}, 32'(bus.fault), 32'(g.st == S_FLT));
        chk({g.tag, ".fc"}, 32'(bus.fault_code), 32'(g.fc));
        chk({g.tag, ".dep"}, 32'(bus.stack_depth), 32'(g.dep));
        @(negedge clk);
        clr();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.ptr_in = '0;
        clr();
        @(negedge clk);

        step("rst", 0, 0, 8'h00, S_IDLE, 0, 0);
        reset = 1'b0;
        step("idle", 0, 0, 8'h00, S_IDLE, 0, 0);
        bus.start = 1'b1;
        step("start", 0, 1, 8'h00, S_RUN, 0, 0);
        step("inc0", 1, 0, 8'h00, S_RUN, 0, 0);
        step("inc1", 1, 0, 8'h00, S_RUN, 0, 0);

        bus.ptr_in = 8'h05; bus.call_req = 1'b1; bus.call_addr = 8'h40;
        step("call", 0, 1, 8'h40, S_RUN, 0, 1);
        bus.ret_req = 1'b1;
        step("ret", 0, 1, 8'h06, S_RUN, 0, 0);
        bus.jump_req = 1'b1; bus.jump_addr = 8'h33;
        step("jump", 0, 1, 8'h33, S_RUN, 0, 0);

        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1; bus.ptr_in = 8'h10;
            bus.call_req = 1'b1; bus.call_addr = 8'h20;
            bus.jump_req = 1'b1; bus.jump_addr = 8'h99;
            step("stall", 0, 0, 8'h00, S_RUN, 0, 0);
        end
        bus.call_req = 1'b1; bus.call_addr = 8'h20;
        bus.jump_req = 1'b1; bus.jump_addr = 8'h99;
        step("unstall", 0, 1, 8'h20, S_RUN, 0, 1);
        bus.ret_req = 1'b1; bus.call_req = 1'b1; bus.call_addr = 8'h77;
        step("retwin", 0, 1, 8'h11, S_RUN, 0, 0);

        bus.ptr_in = 8'hFF; bus.call_req = 1'b1; bus.call_addr = 8'h50;
        step("wrapcall", 0, 1, 8'h50, S_RUN, 0, 1);
        bus.ret_req = 1'b1;
        step("wrapret", 0, 1, 8'h00, S_RUN, 0, 0);

        for (int i = 0; i < 8; i++) begin
            bus.ptr_in = 8'(i); bus.call_req = 1'b1; bus.call_addr = 8'(8'h80 + i);
            step("nest", 0, 1, 8'(8'h80 + i), S_RUN, 0, 4'(i + 1));
        end
        bus.call_req = 1'b1; bus.call_addr = 8'hEE;
        step("ovf", 0, 0, 8'h00, S_FLT, 1, 8);
        bus.start = 1'b1;
        step("ovfhold", 0, 0, 8'h00, S_FLT, 1, 8);
        bus.fault_clr = 1'b1;
        step("clr1", 0, 0, 8'h00, S_IDLE, 0, 0);

        bus.start = 1'b1;
        step("start2", 0, 1, 8'h00, S_RUN, 0, 0);
        bus.ret_req = 1'b1;
        step("udf", 0, 0, 8'h00, S_FLT, 2, 0);
        bus.start = 1'b1;
        step("udfhold", 0, 0, 8'h00, S_FLT, 2, 0);
        bus.fault_clr = 1'b1;
        step("clr2", 0, 0, 8'h00, S_IDLE, 0, 0);

        bus.start = 1'b1;
        step("start3", 0, 1, 8'h00, S_RUN, 0, 0);
        bus.halt_req = 1'b1; bus.jump_req = 1'b1; bus.jump_addr = 8'h12;
        step("halt", 0, 0, 8'h00, S_HALT, 0, 0);
        bus.jump_req = 1'b1; bus.jump_addr = 8'h12;
        step("halted", 0, 0, 8'h00, S_HALT, 0, 0);
        bus.start = 1'b1;
        step("restart", 0, 1, 8'h00, S_RUN, 0, 0);
        bus.start = 1'b1;
        step("startrun", 1, 0, 8'h00, S_RUN, 0, 0);

        reset = 1'b1;
        bus.ptr_in = 8'h07; bus.call_req = 1'b1; bus.call_addr = 8'h44;
        step("rstcall", 0, 0, 8'h00, S_IDLE, 0, 0);
        reset = 1'b0;
        bus.start = 1'b1;
        step("start4", 0, 1, 8'h00, S_RUN, 0, 0);
        bus.ret_req = 1'b1;
        step("nopush", 0, 0, 8'h00, S_FLT, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_flow_ctrl.md
Name: instr_flow_ctrl

Overview:
Program-flow controller that sequences the instruction pointer of one distributed-processor core. It drives the pointer's enable, load-enable and load-value inputs each cycle. It arbitrates start, halt, jump, call and return requests from the decoder, and keeps a hardware return-address stack. Outputs are Mealy, so the pointer register sees a load in the same cycle the request is accepted.

Parameters:
WIDTH, 8, instruction address width; must match the pointer width
STACK_DEPTH, 8, number of return-address stack entries (power of two, at least 2)
START_ADDR, 0, address loaded on start

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  1-cycle pulse; begins execution from START_ADDR
stall  in  1  freeze the pointer; requests are ignored while high
halt_req  in  1  stop execution
jump_req  in  1  unconditional jump request
jump_addr  in  WIDTH  jump target
call_req  in  1  subroutine call request
call_addr  in  WIDTH  call target
ret_req  in  1  return request
fault_clr  in  1  clear a fault and return to IDLE
ptr_in  in  WIDTH  current pointer value (the pointer's ptr_out)
ptr_enable  out  1  advance the pointer by 1
ptr_load_enable  out  1  load ptr_load_val into the pointer
ptr_load_val  out  WIDTH  load value
ptr_reset  out  1  pointer reset (equals reset)
running  out  1  state==RUN
halted  out  1  state==HALTED
fault  out  1  state==FAULT
fault_code  out  2  0=none, 1=stack overflow, 2=stack underflow; sticky
stack_depth  out  clog2(STACK_DEPTH)+1  current stack occupancy

Behaviour:
- State is registered; ptr_enable, ptr_load_enable and ptr_load_val are combinational from state and inputs. Loads therefore take effect in the same cycle.
- Reset: state=IDLE, sp=0, fault_code=0, ptr_reset=1. All other outputs are 0 and stack contents are don't-care.
- Reset mid-operation aborts any accepted request. Pointer and stack state are discarded.
- Defaults when no other rule applies: ptr_enable=0, ptr_load_enable=0, ptr_load_val=0.
- IDLE:
  - start=1 -> ptr_load_enable=1, ptr_load_val=START_ADDR, sp<=0, next state RUN.
  - All other inputs are ignored.
- RUN, stall=1: all strobes are 0 and no state or stack change. The requester must hold its request until stall drops.
- RUN, stall=0: exactly one action is taken, in fixed priority halt > ret > call > jump > increment.
  - halt_req: strobes 0, next state HALTED.
  - ret_req with sp==0: no load, fault_code<=2, next state FAULT.
  - ret_req with sp>0: ptr_load_enable=1, ptr_load_val=stack[sp-1], sp<=sp-1.
  - call_req with sp==STACK_DEPTH: no load, fault_code<=1, next state FAULT.
  - call_req with sp<STACK_DEPTH: stack[sp]<=ptr_in+1 (mod 2^WIDTH, so all-ones wraps to 0), sp<=sp+1, ptr_load_enable=1, ptr_load_val=call_addr.
  - jump_req: ptr_load_enable=1, ptr_load_val=jump_addr.
  - No request: ptr_enable=1.
- Lower-priority requests in the same cycle are dropped, not queued.
- start is ignored in RUN.
- HALTED:
  - Strobes 0.
  - start -> same as start from IDLE (reload START_ADDR, sp cleared, RUN).
- FAULT:
  - Strobes 0; fault_code holds its value.
  - fault_clr -> IDLE, fault_code<=0, sp<=0.
  - start is ignored until the fault is cleared.
- stack_depth always reflects sp after the last clock edge. Push and pop never occur in the same cycle.

Test Plan:
- Reset, then start with START_ADDR=0 -> same cycle load_enable=1 and load_val=0; following idle cycles give ptr_enable=1 each cycle and running=1.
- ptr_in=5, call_req with call_addr=0x40 -> load 0x40, stack_depth=1. Later ret_req -> load 6, stack_depth=0.
- Nine nested calls with STACK_DEPTH=8 -> 9th call gives no load, fault=1, fault_code=1. Then fault_clr -> IDLE, stack_depth=0, fault_code=0.
- ret_req with empty stack -> fault_code=2. A subsequent start is ignored until fault_clr.
- call_req and jump_req held through 3 stall cycles -> strobes 0 during the stall. Cycle after stall drops: call accepted, load call_addr, jump dropped. Also check ret_req+call_req together with sp=1 -> ret wins.
- ptr_in=0xFF, call_req -> pushed value 0x00. Separately, reset asserted during a call cycle -> no push, stack_depth=0, state IDLE.
